sparse_block_scheduler: RTL and testbench

Sequences reads of a block-partitioned flag/activation RAM for the sparsity datapath. On a start pulse it scans a per-block valid bitmap and skips invalid blocks at one cycle each. For each valid block it issues BLOCK_WIDTH read addresses to the RAM port through a req/ready handshake. When padding is enabled it repeats the last address of each block once (row padding). It reports the current block index, a skipped-block count and a done pulse to the layer controller.

---
 rtl/sparse_block_scheduler.sv | 150 +++++++++++++++
 tb/tb_sparse_block_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_block_scheduler.sv
// Sparse block read scheduler: scans a latched per-block valid bitmap,
// skips invalid blocks at one cycle each and issues BLOCK_WIDTH read
// addresses per valid block over a req/ready handshake, optionally
// repeating the final address of each block once (row padding).
module sparse_block_scheduler #(
    parameter int NUM_BLOCK   = 16,
    parameter int BLOCK_WIDTH = 10,
    parameter int ADDR_WIDTH  = 8,
    parameter int BLK_W       = 4,
    parameter int CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  start,
    input  logic [NUM_BLOCK-1:0]  valid_mask,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  pad_en,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_ready,
    output logic                  blk_last,
    output logic [BLK_W-1:0]      blk_idx,
    output logic [CNT_W-1:0]      skip_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int OFF_W = $clog2(BLOCK_WIDTH);
    localparam logic [OFF_W-1:0]      OFF_LAST = OFF_W'(BLOCK_WIDTH - 1);
    localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(NUM_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] BW_A     = ADDR_WIDTH'(BLOCK_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [NUM_BLOCK-1:0]    mask_q, mask_n;
    logic [ADDR_WIDTH-1:0]   base_q, base_n;
    logic                    pad_q, pad_n;
    logic [BLK_W-1:0]        blk_q, blk_n;
    logic [CNT_W-1:0]        skip_q, skip_n;
    logic [OFF_W-1:0]        off_q, off_n;
    logic                    pad_done_q, pad_done_n;
    logic                    is_last;

    // Final issue of a block: last offset, and the padded repeat already sent if padding is on.
    always_comb begin
        is_last = (off_q == OFF_LAST) && (!pad_q || pad_done_q);
    end

    // State and datapath registers; everything freezes while clk_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask_q     <= '0;
            base_q     <= '0;
            pad_q      <= 1'b0;
            blk_q      <= '0;
            skip_q     <= '0;
            off_q      <= '0;
            pad_done_q <= 1'b0;
        end else if (clk_en) begin
            state      <= state_n;
            mask_q     <= mask_n;
            base_q     <= base_n;
            pad_q      <= pad_n;
            blk_q      <= blk_n;
            skip_q     <= skip_n;
            off_q      <= off_n;
            pad_done_q <= pad_done_n;
        end
    end

    // Next-state and next-datapath logic for the scan/issue sequencer.
    always_comb begin
        state_n    = state;
        mask_n     = mask_q;
        base_n     = base_q;
        pad_n      = pad_q;
        blk_n      = blk_q;
        skip_n     = skip_q;
        off_n      = off_q;
        pad_done_n = pad_done_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mask_n     = valid_mask;
                    base_n     = base_addr;
                    pad_n      = pad_en;
                    blk_n      = '0;
                    skip_n     = '0;
                    off_n      = '0;
                    pad_done_n = 1'b0;
                    state_n    = SCAN;
                end
            end
            SCAN: begin
                if (mask_q[blk_q]) begin
                    off_n      = '0;
                    pad_done_n = 1'b0;
                    state_n    = ISSUE;
                end else begin
                    skip_n = skip_q + CNT_W'(1);
                    if (blk_q == BLK_LAST) state_n = DONE;
                    else                   blk_n   = blk_q + BLK_W'(1);
                end
            end
            ISSUE: begin
                if (rd_ready) begin
                    if (is_last) begin
                        if (blk_q == BLK_LAST) begin
                            state_n = DONE;
                        end else begin
                            blk_n   = blk_q + BLK_W'(1);
                            state_n = SCAN;
                        end
                    end else if (off_q != OFF_LAST) begin
                        off_n = off_q + OFF_W'(1);
                    end else begin
                        // offset holds so the same final address is reissued once
                        pad_done_n = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from registered state; address wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        rd_req   = (state == ISSUE);
        rd_addr  = '0;
        if (state == ISSUE)
            rd_addr = base_q + ADDR_WIDTH'(blk_q) * BW_A + ADDR_WIDTH'(off_q);
        blk_last = (state == ISSUE) && is_last;
        blk_idx  = blk_q;
        skip_cnt = skip_q;
        busy     = (state == SCAN) || (state == ISSUE);
        done     = (state == DONE);
    end

endmodule

// File: tb/tb_sparse_block_scheduler.sv
// Directed testbench for sparse_block_scheduler: table of complete scans
// plus hand-written backpressure, clk_en, restart and reset sequences.
module tb_sparse_block_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b1;
    logic       start = 1'b0;
    logic [15:0] valid_mask = '0;
    logic [7:0] base_addr = '0;
    logic       pad_en = 1'b0;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ready = 1'b1;
    logic       blk_last;
    logic [3:0] blk_idx;
    logic [4:0] skip_cnt;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    sparse_block_scheduler #(
        .NUM_BLOCK(16), .BLOCK_WIDTH(10), .ADDR_WIDTH(8), .BLK_W(4), .CNT_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
        .valid_mask(valid_mask), .base_addr(base_addr), .pad_en(pad_en),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .blk_last(blk_last), .blk_idx(blk_idx), .skip_cnt(skip_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One complete scan with rd_ready held high. Accepted addresses and
    // blk_last are checked against a list built from the block layout.
    // With poke set, a start with different inputs is pulsed during ISSUE
    // and again during DONE; both must be ignored.
    task automatic run_scan(input logic [15:0] m, input logic [7:0] b, input logic p,
                            input bit poke, output int reads, output int skip,
                            output int cyc, output logic [7:0] first_a, output logic [7:0] last_a);
        logic [7:0] ea[$];
        logic       el[$];
        int         k;
        bit         fin;
        for (int blk = 0; blk < 16; blk++) begin
            if (m[blk]) begin
                for (int o = 0; o < 10; o++) begin
                    ea.push_back(8'(b + 8'(blk * 10 + o)));
                    el.push_back(o == 9 && !p);
                end
                if (p) begin
                    ea.push_back(8'(b + 8'(blk * 10 + 9)));
                    el.push_back(1'b1);
                end
            end
        end
        @(negedge clk);
        valid_mask = m; base_addr = b; pad_en = p; start = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("scan_busy_k0", busy, 1);
        check("scan_skip_k0", skip_cnt, 0);
        check("scan_blk_k0", blk_idx, 0);
        reads = 0; fin = 0; cyc = -1; k = 0; first_a = '0; last_a = '0;
        while (!fin && k < 400) begin
            if (poke && k == 3) begin
                start = 1'b1; valid_mask = 16'hFFFF; base_addr = 8'h55; pad_en = ~p;
            end else if (poke && k == 4) begin
                start = 1'b0;
            end
            if (rd_req && rd_ready) begin
                if (reads < ea.size()) begin
                    check("issue_addr", rd_addr, ea[reads]);
                    check("issue_last", blk_last, el[reads]);
                end else begin
                    check("extra_read", 1, 0);
                end
                if (reads == 0) first_a = rd_addr;
                last_a = rd_addr;
                reads++;
            end
            if (done) begin
                fin = 1; cyc = k;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("scan_finished", fin, 1);
        skip = skip_cnt;
        check("done_busy_low", busy, 0);
        if (poke) begin
            start = 1'b1; valid_mask = 16'hFFFF;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_single_pulse", done, 0);
        check("idle_after_done", busy, 0);
        @(negedge clk);
        check("still_idle", busy, 0);
        check("skip_holds", skip_cnt, 32'(skip));
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  base;
        logic        pad;
        int          reads;
        int          skip;
        int          cyc;
        logic [7:0]  first_a;
        logic [7:0]  last_a;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int reads, skip, cyc, n;
        logic [7:0] fa, la;
        bit hit;

        vecs[0] = '{16'hFFFF, 8'h00, 1'b0, 160,  0, 176, 8'h00, 8'h9F};
        vecs[1] = '{16'h0005, 8'h10, 1'b1,  22, 14,  38, 8'h10, 8'h2D};
        vecs[2] = '{16'h0000, 8'h00, 1'b0,   0, 16,  16, 8'h00, 8'h00};
        vecs[3] = '{16'h0003, 8'hF0, 1'b0,  20, 14,  36, 8'hF0, 8'h03};
        vecs[4] = '{16'h8000, 8'h00, 1'b0,  10, 15,  26, 8'h96, 8'h9F};
        vecs[5] = '{16'h0001, 8'hFF, 1'b1,  11, 15,  27, 8'hFF, 8'h08};

        // reset values
        #12;
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_blk_last", blk_last, 0);
        check("rst_blk_idx", blk_idx, 0);
        check("rst_skip", skip_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].mask, vecs[i].base, vecs[i].pad, 1'b0, reads, skip, cyc, fa, la);
            check($sformatf("v%0d_reads", i), reads, vecs[i].reads);
            check($sformatf("v%0d_skip", i), skip, vecs[i].skip);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            if (vecs[i].reads > 0) begin
                check($sformatf("v%0d_first", i), fa, vecs[i].first_a);
                check($sformatf("v%0d_last", i), la, vecs[i].last_a);
            end
        end

        // start pulses in ISSUE and DONE ignored; later start re-latches and clears skip_cnt
        run_scan(16'h0001, 8'h00, 1'b0, 1'b1, reads, skip, cyc, fa, la);
        check("poke_reads", reads, 10);
        check("poke_skip", skip, 15);
        check("poke_cycles", cyc, 26);
        run_scan(16'h0002, 8'h20, 1'b0, 1'b0, reads, skip, cyc, fa, la);
        check("relatch_first", fa, 8'h2A);
        check("relatch_skip", skip, 15);

        // backpressure: hold rd_ready low at offset 4 of block 0
        @(negedge clk);
        valid_mask = 16'h0001; base_addr = 8'h00; pad_en = 1'b0; rd_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int t = 0; t < 30 && !hit; t++) begin
            if (rd_req && rd_addr == 8'h04) begin
                hit = 1; rd_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("bp_reached", hit, 1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("bp_req_hold", rd_req, 1);
            check("bp_addr_hold", rd_addr, 8'h04);
        end
        rd_ready = 1'b1;
        n = 0; hit = 0;
        for (int t = 0; t < 50 && !hit; t++) begin
            if (rd_req && rd_ready) n++;
            if (done) hit = 1;
            else @(negedge clk);
        end
        check("bp_done", hit, 1);
        check("bp_remaining_reads", n, 6);
        check("bp_skip", skip_cnt, 15);
        @(negedge clk);

        // clk_en low for two cycles during SCAN freezes progress
        @(negedge clk);
        valid_mask = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ce_pre_blk", blk_idx, 3);
        check("ce_pre_skip", skip_cnt, 3);
        clk_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("ce_blk_frozen", blk_idx, 3);
            check("ce_skip_frozen", skip_cnt, 3);
        end
        clk_en = 1'b1;
        @(negedge clk);
        check("ce_resume_blk", blk_idx, 4);
        hit = 0;
        for (int t = 0; t < 40 && !hit; t++) begin
            if (done) hit = 1;
            else @(negedge clk);
        end
        check("ce_done", hit, 1);
        check("ce_skip", skip_cnt, 16);
        @(negedge clk);

        // asynchronous reset in the middle of block 3
        @(negedge clk);
        valid_mask = 16'hFFFF; base_addr = 8'h00; pad_en = 1'b0; rd_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            if (rd_req && blk_idx == 4'd3 && rd_addr == 8'h23) hit = 1;
            else @(negedge clk);
        end
        check("rstm_reached", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_rd_req", rd_req, 0);
        check("rstm_rd_addr", rd_addr, 0);
        check("rstm_blk_idx", blk_idx, 0);
        check("rstm_busy", busy, 0);
        check("rstm_done", done, 0);
        @(negedge clk);
        check("rstm_no_done", done, 0);
        rst_n = 1'b1;
        run_scan(16'h0001, 8'h00, 1'b0, 1'b0, reads, skip, cyc, fa, la);
        check("post_rst_reads", reads, 10);
        check("post_rst_skip", skip, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
